// File: rtl/ca_step_engine.sv
// One-dimensional cellular automaton stepper: loads a seed and a rule table,
// then advances the cell vector one generation per clock for a set number of generations.
module ca_step_engine #(
  parameter  int WIDTH = 8,
  parameter  int NBR   = 3,
  localparam int RW    = 2 ** NBR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [RW-1:0]    rule,
  input  logic             wrap,
  input  logic [7:0]       gens,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] cells,
  output logic [7:0]       gen_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_cells;
  logic [RW-1:0]    r_rule;
  logic [7:0]       r_gens;
  logic             r_wrap;
  logic [7:0]       r_gen_cnt;
  logic [7:0]       w_cnt_inc;
  logic [WIDTH-1:0] w_next_cells;

  assign w_cnt_inc = r_gen_cnt + 8'd1;

  // Per-cell neighbourhood lookup; edge neighbours read 0 unless wrapping.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic w_left;
    if (gi == WIDTH - 1) begin : g_left_edge
      assign w_left = r_wrap & r_cells[0];
    end else begin : g_left_inner
      assign w_left = r_cells[gi+1];
    end

    if (NBR == 2) begin : g_nbr2
      assign w_next_cells[gi] = r_rule[{w_left, r_cells[gi]}];
    end else begin : g_nbr3
      logic w_right;
      if (gi == 0) begin : g_right_edge
        assign w_right = r_wrap & r_cells[WIDTH-1];
      end else begin : g_right_inner
        assign w_right = r_cells[gi-1];
      end
      assign w_next_cells[gi] = r_rule[{w_left, r_cells[gi], w_right}];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (gens != 8'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort || (w_cnt_inc == r_gens)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cells   <= '0;
      r_rule    <= '0;
      r_gens    <= '0;
      r_wrap    <= 1'b0;
      r_gen_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_cells <= seed;
            r_rule  <= rule;
          end
          if (start) begin
            r_gens    <= gens;
            r_wrap    <= wrap;
            r_gen_cnt <= '0;
          end
        end
        S_RUN: begin
          // An aborting edge leaves the last completed generation in place.
          if (!abort) begin
            r_cells   <= w_next_cells;
            r_gen_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign cells   = r_cells;
  assign gen_cnt = r_gen_cnt;
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);

endmodule
